// File: rtl/counter_up_down_pkg.sv
// Shared types for the programmable modulo-N counter.
// Counting direction is kept as an enum so the mode is readable in waveforms.
package counter_up_down_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } count_dir_e;

endpackage : counter_up_down_pkg

// File: rtl/counter_up_down.sv
// Registered modulo-N counter with a runtime modulus; data == 0 selects 2^WIDTH.
// COUNT_DOWN picks the direction at elaboration time.
module counter_up_down
    import counter_up_down_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int COUNT_DOWN = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             counter_en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] sum
);

    localparam count_dir_e DIR = (COUNT_DOWN != 0) ? DIR_DOWN : DIR_UP;

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;

    // Last legal value is M-1, held one bit wider so data == 0 gives 2^WIDTH-1 cleanly.
    function automatic logic [WIDTH-1:0] next_count(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] modulus
    );
        logic [WIDTH:0]   last;
        logic [WIDTH:0]   cur_ext;
        logic [WIDTH-1:0] nxt;

        cur_ext = {1'b0, cur};
        if (modulus == '0) begin
            last = {1'b0, {WIDTH{1'b1}}};
        end else begin
            last = {1'b0, modulus} - {{WIDTH{1'b0}}, 1'b1};
        end

        if (DIR == DIR_UP) begin
            if (cur_ext >= last) begin
                nxt = '0;
            end else begin
                nxt = cur + WIDTH'(1);
            end
        end else begin
            if ((cur == '0) || (cur_ext > last)) begin
                nxt = last[WIDTH-1:0];
            end else begin
                nxt = cur - WIDTH'(1);
            end
        end
        return nxt;
    endfunction

    always_comb begin
        sum_d = sum_q;
        if (counter_en) begin
            sum_d = next_count(sum_q, data);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule : counter_up_down

// File: tb/tb_counter_up_down.sv
// Scoreboard bench: an up and a down counter share stimulus and are checked
// against a modular-arithmetic reference model.
module tb_counter_up_down;

    localparam int WIDTH = 4;
    localparam int FULL  = 1 << WIDTH;

    typedef struct {
        int exp_up;
        int exp_dn;
        int period;
    } sb_entry_t;

    logic             clock;
    logic             reset;
    logic             counter_en;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] sum_up;
    logic [WIDTH-1:0] sum_dn;

    sb_entry_t sb[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int model_up     = 0;
    int model_dn     = 0;
    int edge_count   = 0;
    int last_wrap    = -1;

    counter_up_down #(.WIDTH(WIDTH), .COUNT_DOWN(0)) dut_up (
        .clock(clock), .reset(reset), .counter_en(counter_en), .data(data), .sum(sum_up)
    );

    counter_up_down #(.WIDTH(WIDTH), .COUNT_DOWN(1)) dut_dn (
        .clock(clock), .reset(reset), .counter_en(counter_en), .data(data), .sum(sum_dn)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the count lives in the ring Z_M; anything outside it
    // re-enters at the direction's starting point.
    function automatic int model_next(input int s, input int d, input bit down);
        int m;
        m = (d == 0) ? FULL : d;
        if (s >= m) return down ? m - 1 : 0;
        return down ? (s + m - 1) % m : (s + 1) % m;
    endfunction

    // Drive one cycle of inputs at the falling edge and queue the result for the next rising edge.
    task automatic apply_stimulus(input bit en, input int d, input bit rst_high, input int period);
        sb_entry_t e;
        @(negedge clock);
        reset      = rst_high;
        counter_en = en;
        data       = WIDTH'(d);
        if (!rst_high) begin
            model_up = 0;
            model_dn = 0;
        end else if (en) begin
            model_up = model_next(model_up, d, 1'b0);
            model_dn = model_next(model_dn, d, 1'b1);
        end
        e.exp_up = model_up;
        e.exp_dn = model_dn;
        e.period = period;
        sb.push_back(e);
    endtask

    // Asynchronous reset between edges; the count must clear without a clock.
    task automatic pulse_reset();
        sb_entry_t e;
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check_output("async_reset_up", int'(sum_up), 0);
        check_output("async_reset_dn", int'(sum_dn), 0);
        model_up = 0;
        model_dn = 0;
        e.exp_up = 0;
        e.exp_dn = 0;
        e.period = 0;
        sb.push_back(e);
    endtask

    // Monitor: every rising edge presents a new count, compared against the queued model value.
    always @(posedge clock) begin
        sb_entry_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            edge_count++;
            check_output("up_count", int'(sum_up), e.exp_up);
            check_output("down_count", int'(sum_dn), e.exp_dn);
            if (e.period == 0) begin
                last_wrap = -1;
            end else if (sum_up == '0) begin
                if (last_wrap >= 0) begin
                    check_output("wrap_spacing", edge_count - last_wrap, e.period);
                end
                last_wrap = edge_count;
            end
        end
    end

    initial begin
        reset      = 1'b0;
        counter_en = 1'b1;
        data       = WIDTH'(10);
        #1;
        check_output("reset_up", int'(sum_up), 0);
        check_output("reset_dn", int'(sum_dn), 0);

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 10, 1'b0, 0);

        // data=10 from release: two full wraps land the up counter on 6
        for (int i = 0; i < 26; i++) apply_stimulus(1'b1, 10, 1'b1, 10);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 10, 1'b1, 0);
        apply_stimulus(1'b1, 10, 1'b1, 0);
        apply_stimulus(1'b1, 10, 1'b1, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 5, 1'b1, 0);
        for (int i = 0; i < 17; i++) apply_stimulus(1'b1, 0, 1'b1, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1, 1'b1, 0);

        // Down counter walks 9..4, then reset is pulsed mid-count
        apply_stimulus(1'b1, 10, 1'b0, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 10, 1'b1, 0);
        pulse_reset();
        apply_stimulus(1'b1, 10, 1'b0, 0);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 10, 1'b1, 0);

        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0,
                           int'($urandom_range(0, FULL - 1)),
                           $urandom_range(0, 39) != 0, 0);
        end

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
        #2;
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_counter_up_down

// File: doc/counter_up_down.md
# counter_up_down

Registered modulo-N counter with a runtime-programmable modulus. While enabled, it advances once per clock through 0..N-1 and wraps. A parameter selects whether it counts up or down. It serves as a general-purpose divider/sequencer: the modulus comes from a configuration input, and the count value feeds downstream comparators or displays.

## Interface
- WIDTH, 4: bit width of `data` and `sum`.
- COUNT_DOWN, 0: 0 counts up (0→N-1, wrap to 0); 1 counts down (N-1→0, wrap to N-1).
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; forces `sum` to 0 immediately while low.
- counter_en  input  1  count enable; 1 = advance on this edge, 0 = hold.
- data  input  WIDTH  modulus N, sampled every cycle; 0 means N = 2^WIDTH.
- sum  output  WIDTH  current count, driven directly from the state register.

## Operation
- Effective modulus M = (data == 0) ? 2^WIDTH : data.
- Up mode, counter_en=1:
  - sum ≥ M-1 → sum becomes 0.
  - otherwise → sum becomes sum+1.
- Down mode, counter_en=1:
  - sum == 0 or sum ≥ M → sum becomes M-1.
  - otherwise → sum becomes sum-1.
- counter_en=0: sum holds its value, including an out-of-range value, until the next enabled edge.
- M = 1 (data = 1): sum stays at 0 in both modes.
- A data change takes effect on the next enabled edge with no pipelining.
  - If the new M is not above the current sum, up mode wraps to 0 and down mode loads M-1 on that edge.
- Arithmetic is WIDTH bits, unsigned.
  - Compute M-1 in WIDTH+1 bits so the data=0 case yields 2^WIDTH-1 without overflow.
  - No value of sum or data produces X or an out-of-range result after one enabled edge.
- Reset has priority over enable. Reset in the middle of a count aborts it, and sum is 0 while reset is low.

## Timing
- One register stage; sum changes only on a rising clock edge or on assertion of reset.
- Latency: a counter_en/data value present before edge k determines sum after edge k.
- Reset assertion: sum = 0 asynchronously, with no clock needed.
- Reset deassertion is synchronized externally to clock.
- The first rising edge with reset high and counter_en=1 performs the first step:
  - up mode: 0 → 1.
  - down mode: 0 → M-1.
- Period in steady enabled operation: exactly M clocks between successive wraps.
- No handshake; counter_en is level-sensitive, one step per enabled edge.

## Structure
- Single module, no sub-modules. A combinational next-value block feeds one always-block register with asynchronous reset.
- No shared package is required.
  - The optional shared constant is the data=0 → 2^WIDTH modulus rule, if other counters in the design adopt it.
- Keep the next-state logic in a local function so up and down modes share the wrap/out-of-range checks.

## Test plan
- Reset low, counter_en=1, data=10, clock running → sum = 0 on every edge.
- Release reset, data=10, up mode:
  - sum reads 1,2,…,9,0,1 on successive edges.
  - wrap spacing is 10 clocks.
- counter_en=0 for 3 cycles at sum=6 → sum stays 6; re-enable → 7.
- At sum=8, change data to 5 → next edge 0, then 1,2,3,4,0.
- data=0 → 0..15 then 0; data=1 → constant 0.
- COUNT_DOWN=1, data=10:
  - after reset: 9,8,…,0,9.
  - reset pulsed low mid-count at sum=4 → sum = 0 immediately (before the next clock); then 9 on the first enabled edge after release.
